// File: rtl/mgr_sync_pkg.sv
// mgr_sync_pkg: shared state encoding, default sizes and width helper for the manager-array barrier.
package mgr_sync_pkg;
  typedef enum logic [1:0] {IDLE, GATHER, RELEASE, ERROR} sync_state_e;
  localparam int DEF_NUM_MGR = 64;
  localparam int DEF_TIMEOUT_W = 16;
  localparam int DEF_EPOCH_W = 8;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/mgr_sync_popcount.sv
// mgr_sync_popcount: combinational adder-tree population count over N bits.
module mgr_sync_popcount
  import mgr_sync_pkg::*;
#(
  parameter int N = DEF_NUM_MGR,
  parameter int W = cnt_w(N)
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);
  localparam int P = 1 << $clog2(N);
  // heap-ordered tree: leaves at P..2P-1, node i sums children 2i and 2i+1
  logic [W-1:0] t [1:2*P-1];
  always_comb begin
    for (int i = 1; i < 2 * P; i++) t[i] = '0;
    for (int k = 0; k < N; k++) t[P+k] = W'(bits[k]);
    for (int i = P - 1; i >= 1; i--) t[i] = t[2*i] + t[2*i+1];
  end
  assign count = t[1];
endmodule

// File: rtl/mgr_array_sync_cntl.sv
// mgr_array_sync_cntl: barrier controller gathering masked manager arrivals and issuing a one-cycle release.
module mgr_array_sync_cntl
  import mgr_sync_pkg::*;
#(
  parameter int NUM_MGR = DEF_NUM_MGR,
  parameter int TIMEOUT_W = DEF_TIMEOUT_W,
  parameter int EPOCH_W = DEF_EPOCH_W,
  parameter int CNT_W = cnt_w(NUM_MGR)
) (
  input  logic                 clk,
  input  logic                 reset_poweron,
  input  logic [NUM_MGR-1:0]   mgr__sys__allSynchronized,
  input  logic                 cfg__sync__enable,
  input  logic [NUM_MGR-1:0]   cfg__sync__mask,
  input  logic [TIMEOUT_W-1:0] cfg__sync__timeout,
  input  logic                 cfg__sync__clear,
  output logic [NUM_MGR-1:0]   sys__mgr__thisSynchronized,
  output logic                 sync__sys__busy,
  output logic [EPOCH_W-1:0]   sync__sys__epoch,
  output logic [CNT_W-1:0]     sync__sys__arrivedCount,
  output logic                 sync__sys__timeout,
  output logic [NUM_MGR-1:0]   sync__sys__missing,
  output logic                 sync__sys__error
);
  sync_state_e state, state_n;
  logic [NUM_MGR-1:0] mask_q, mask_n, arrived_q, arrived_n, prev_q, pending_q, pending_n;
  logic [NUM_MGR-1:0] missing_q, missing_n, release_q, rise;
  logic [TIMEOUT_W-1:0] timer_q, timer_n;
  logic [EPOCH_W-1:0] epoch_q, epoch_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic timeout_q, arm;
  assign rise = mgr__sys__allSynchronized & ~prev_q;
  always_comb begin
    state_n = state;
    mask_n = mask_q;
    arrived_n = arrived_q;
    pending_n = pending_q;
    missing_n = missing_q;
    timer_n = timer_q;
    epoch_n = epoch_q;
    arm = 1'b0;
    case (state)
      IDLE: arm = cfg__sync__enable && |cfg__sync__mask;
      GATHER: begin
        if (!cfg__sync__enable) begin
          state_n = IDLE;
          arrived_n = '0;
        end else begin
          arrived_n = arrived_q | (rise & mask_q);
          // completion is tested before expiry so a last-cycle arrival still releases
          if ((arrived_n & mask_q) == mask_q) state_n = RELEASE;
          else if (timer_q == TIMEOUT_W'(1)) begin
            state_n = ERROR;
            missing_n = mask_q & ~arrived_n;
          end else if (timer_q != '0) timer_n = timer_q - TIMEOUT_W'(1);
        end
      end
      RELEASE: begin
        epoch_n = epoch_q + EPOCH_W'(1);
        pending_n = pending_q | rise;
        arm = cfg__sync__enable && |cfg__sync__mask;
        if (!arm) begin
          state_n = IDLE;
          arrived_n = '0;
        end
      end
      default: if (cfg__sync__clear) begin
        state_n = IDLE;
        arrived_n = '0;
        missing_n = '0;
      end
    endcase
    // a zero timer never reaches 1, so it doubles as the "no timeout" marker
    if (arm) begin
      state_n = GATHER;
      mask_n = cfg__sync__mask;
      arrived_n = pending_n & cfg__sync__mask;
      pending_n = '0;
      timer_n = cfg__sync__timeout;
    end
  end
  mgr_sync_popcount #(.N(NUM_MGR), .W(CNT_W)) u_popcount (
    .bits  (arrived_n & mask_n),
    .count (count_n)
  );
  always_ff @(posedge clk) begin
    if (!reset_poweron) begin
      state <= IDLE;
      mask_q <= '0;
      arrived_q <= '0;
      prev_q <= '0;
      pending_q <= '0;
      missing_q <= '0;
      release_q <= '0;
      timer_q <= '0;
      epoch_q <= '0;
      count_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_n;
      mask_q <= mask_n;
      arrived_q <= arrived_n;
      prev_q <= mgr__sys__allSynchronized;
      pending_q <= pending_n;
      missing_q <= missing_n;
      release_q <= (state_n == RELEASE) ? mask_q : '0;
      timer_q <= timer_n;
      epoch_q <= epoch_n;
      count_q <= count_n;
      timeout_q <= (state == GATHER) && (state_n == ERROR);
    end
  end
  assign sys__mgr__thisSynchronized = release_q;
  assign sync__sys__busy = (state == GATHER) || (state == RELEASE);
  assign sync__sys__epoch = epoch_q;
  assign sync__sys__arrivedCount = count_q;
  assign sync__sys__timeout = timeout_q;
  assign sync__sys__missing = missing_q;
  assign sync__sys__error = (state == ERROR);
endmodule

// File: tb/tb_mgr_array_sync_cntl.sv
// tb_mgr_array_sync_cntl: directed stimulus with a scoreboard of expected release/timeout events.
module tb_mgr_array_sync_cntl;
  localparam int N = 8;
  localparam int TW = 8;
  localparam int EW = 2;
  localparam int CW = 4;
  typedef struct {
    bit is_to;
    logic [N-1:0] data;
    int cyc;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] mgr, mask;
  logic en, clr;
  logic [TW-1:0] tmo;
  logic [N-1:0] rel, missing;
  logic busy, to, err;
  logic [EW-1:0] epoch;
  logic [CW-1:0] cnt;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  ev_t sb[$];
  mgr_array_sync_cntl #(.NUM_MGR(N), .TIMEOUT_W(TW), .EPOCH_W(EW), .CNT_W(CW)) dut (
    .clk                        (clk),
    .reset_poweron              (rst_n),
    .mgr__sys__allSynchronized  (mgr),
    .cfg__sync__enable          (en),
    .cfg__sync__mask            (mask),
    .cfg__sync__timeout         (tmo),
    .cfg__sync__clear           (clr),
    .sys__mgr__thisSynchronized (rel),
    .sync__sys__busy            (busy),
    .sync__sys__epoch           (epoch),
    .sync__sys__arrivedCount    (cnt),
    .sync__sys__timeout         (to),
    .sync__sys__missing         (missing),
    .sync__sys__error           (err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_ev(input bit is_to, input logic [N-1:0] data, input int at);
    ev_t e;
    e.is_to = is_to;
    e.data = data;
    e.cyc = at;
    sb.push_back(e);
  endtask
  always @(negedge clk) begin
    if (rel != '0 || to) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: rel=%0h timeout=%0b missing=%0h cycle %0d", rel, to, missing, cyc);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check(e.is_to ? "timeout_kind" : "release_kind", {31'd0, to}, {31'd0, e.is_to});
        check(e.is_to ? "missing_value" : "release_value", e.is_to ? 32'(missing) : 32'(rel), 32'(e.data));
        check("event_cycle", cyc, e.cyc);
        if (e.is_to) check("no_release_on_timeout", 32'(rel), 0);
      end
    end
  end
  initial begin
    int b;
    rst_n = 1'b0; mgr = '0; mask = '0; en = 1'b0; clr = 1'b0; tmo = '0;
    tick(2);
    check("reset_outputs", {rel, busy, epoch, cnt, to, missing, err}, 0);
    rst_n = 1'b1;
    tick();
    // basic barrier on managers 0..3
    b = cyc; mask = 8'h0F; tmo = 0; en = 1'b1;
    tick(2);
    check("basic_busy", {31'd0, busy}, 1);
    mgr = 8'h01;
    tick(3);
    check("basic_count1", cnt, 1);
    mgr = 8'h07;
    tick(4);
    check("basic_count3", cnt, 3);
    mgr = 8'h0F;
    expect_ev(0, 8'h0F, b + 10);
    tick();
    check("basic_count4", cnt, 4);
    en = 1'b0;
    tick();
    check("basic_epoch", epoch, 1);
    check("basic_idle", {31'd0, busy}, 0);
    // timeout with manager 7 missing
    mgr = '0;
    tick();
    b = cyc; mask = 8'hFF; tmo = 20; en = 1'b1;
    tick(2);
    mgr = 8'h7F;
    expect_ev(1, 8'h80, b + 21);
    tick();
    check("to_count7", cnt, 7);
    tick(18);
    check("to_error", {31'd0, err}, 1);
    check("to_not_busy", {31'd0, busy}, 0);
    en = 1'b0;
    tick(3);
    check("to_error_held", {31'd0, err}, 1);
    check("to_missing_held", missing, 8'h80);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clear_error", {31'd0, err}, 0);
    check("clear_missing", missing, 0);
    check("clear_idle", {31'd0, busy}, 0);
    // final arrival lands on the expiry cycle
    mgr = '0;
    tick();
    b = cyc; mask = 8'h03; tmo = 4; en = 1'b1;
    tick();
    mgr = 8'h01;
    tick(3);
    mgr = 8'h03;
    expect_ev(0, 8'h03, b + 5);
    tick();
    en = 1'b0;
    tick();
    check("simul_no_error", {31'd0, err}, 0);
    check("simul_epoch", epoch, 2);
    // auto re-arm with manager 2 re-arriving during release
    mgr = '0;
    tick();
    b = cyc; mask = 8'h0C; tmo = 0; en = 1'b1;
    tick();
    mgr = 8'h04;
    tick();
    mgr = 8'h00;
    tick();
    mgr = 8'h08;
    expect_ev(0, 8'h0C, b + 4);
    tick();
    mgr = 8'h0C;
    tick();
    check("rearm_busy", {31'd0, busy}, 1);
    check("rearm_pending_count", cnt, 1);
    check("rearm_epoch", epoch, 3);
    mgr = 8'h04;
    tick();
    mgr = 8'h0C;
    expect_ev(0, 8'h0C, b + 7);
    tick();
    en = 1'b0;
    tick();
    check("epoch_wrap", epoch, 0);
    check("rearm_idle", {31'd0, busy}, 0);
    // abort mid-gather
    mgr = '0;
    tick();
    mask = 8'h0F; en = 1'b1;
    tick();
    mgr = 8'h01;
    tick();
    check("abort_count_before", cnt, 1);
    en = 1'b0;
    tick();
    check("abort_idle", {31'd0, busy}, 0);
    check("abort_cleared", cnt, 0);
    check("abort_epoch", epoch, 0);
    // reset mid-gather
    mgr = '0;
    tick();
    en = 1'b1;
    tick(2);
    mgr = 8'h07;
    tick();
    check("rst_mid_count", cnt, 3);
    mgr = 8'h0F;
    rst_n = 1'b0;
    tick();
    check("rst_mid_outputs", {rel, busy, epoch, cnt, to, missing, err}, 0);
    rst_n = 1'b1; en = 1'b0; mgr = '0;
    tick(2);
    // zero mask never arms
    mask = '0; en = 1'b1;
    tick(3);
    check("mask0_idle", {31'd0, busy}, 0);
    check("mask0_no_error", {31'd0, err}, 0);
    en = 1'b0;
    tick(3);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
